// File: rtl/gf2_div_pkg.sv
// Shared constants and types for the GF(2)[x] 39-by-20 long divider.
// Widths are derived from the divisor width M.
package gf2_div_pkg;

  localparam int M  = 20;
  localparam int N  = 2*M-1;
  localparam int QW = N-M+1;
  localparam int RW = M-1;
  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/gf2_div_step.sv
// One carry-less long-division step: inspect W bit M-1+k and
// cancel it with the divisor shifted by k when it is set.
module gf2_div_step
  import gf2_div_pkg::*;
(
  input  logic [N-1:0]  i_w,
  input  logic [M-1:0]  i_d,
  input  logic [CW-1:0] i_k,
  output logic [N-1:0]  o_w,
  output logic          o_qb
);

  logic [5:0]   w_pos;
  logic [N-1:0] w_dsh;

  assign w_pos = 6'(M-1) + {1'b0, i_k};
  assign w_dsh = {{(N-M){1'b0}}, i_d} << i_k;
  assign o_qb  = i_w[w_pos];
  assign o_w   = o_qb ? (i_w ^ w_dsh) : i_w;

endmodule

// File: rtl/gf2_poly_div_39by20.sv
// Sequential carry-less divider: A(39b) / B(20b, deg 19) -> Q, R.
// Retires one quotient bit per clock, MSB first.
module gf2_poly_div_39by20
  import gf2_div_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a_in,
  input  logic [M-1:0]  b_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] q_out,
  output logic [RW-1:0] r_out,
  output logic          div_err
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_w;
  logic [M-1:0]  r_d;
  logic [QW-1:0] r_q;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic [N-1:0]  w_step_w;
  logic          w_qb;
  logic          w_accept;

  gf2_div_step u_step (
    .i_w  (r_w),
    .i_d  (r_d),
    .i_k  (r_cnt),
    .o_w  (w_step_w),
    .o_qb (w_qb)
  );

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;
  assign q_out     = r_q;
  assign r_out     = r_w[RW-1:0];
  assign div_err   = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept)
          w_state_nxt = b_in[M-1] ? RUN : DONE;
      end
      RUN: begin
        if (r_cnt == '0) w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // An invalid divisor leaves W cleared so the remainder reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w   <= '0;
      r_d   <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_d   <= b_in;
            r_q   <= '0;
            r_cnt <= CW'(QW-1);
            if (b_in[M-1]) begin
              r_w   <= a_in;
              r_err <= 1'b0;
            end else begin
              r_w   <= '0;
              r_err <= 1'b1;
            end
          end
        end
        RUN: begin
          r_w   <= w_step_w;
          r_q   <= {r_q[QW-2:0], w_qb};
          r_cnt <= r_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!rst && r_state == DONE)
      assert (r_w[N-1:RW] == '0)
        else $error("divider high bits not cleared at DONE");
  end

endmodule
